// File: rtl/tone_meter.sv
// tone_meter: measures an incoming square-wave tone on a single pin.
// Reports the last complete half-period in microseconds, the tone duration
// (first edge to last edge) in milliseconds and the edge count, then holds
// the result behind a valid/ack handshake until the consumer accepts it.
// The duration output is named time_ms because "time" is a reserved word.
module tone_meter #(
  parameter int unsigned CLK_F      = 25,  // clocks per microsecond
  parameter int unsigned TIMEOUT_MS = 10   // silence that ends a tone, >= 1
) (
  input  logic        CLK,
  input  logic        RESET_N,
  input  logic        enable,
  input  logic        tone_in,
  input  logic        ack,
  output logic [31:0] period,
  output logic [31:0] time_ms,
  output logic [31:0] edges,
  output logic        valid,
  output logic        busy
);

  localparam logic [31:0] US_LAST    = 32'(CLK_F - 1);
  localparam logic [31:0] MS_LAST    = 32'(CLK_F * 1000 - 1);
  localparam logic [31:0] TIMEOUT_US = 32'(TIMEOUT_MS * 1000);
  localparam logic [31:0] SAT_MAX    = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  // Saturating increment shared by every 32-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == SAT_MAX) ? v : v + 32'd1;
  endfunction

  state_t      state_q, state_d;
  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        sync3_q, sync3_d;
  logic [31:0] us_pre_q, us_pre_d;
  logic [31:0] us_cnt_q, us_cnt_d;
  logic [31:0] clk_ms_q, clk_ms_d;
  logic [31:0] ms_cnt_q, ms_cnt_d;
  logic [31:0] edge_cnt_q, edge_cnt_d;
  logic [31:0] last_half_q, last_half_d;
  logic [31:0] last_ms_q, last_ms_d;
  logic        have_period_q, have_period_d;
  logic [31:0] period_q, period_d;
  logic [31:0] time_q, time_d;
  logic [31:0] edges_q, edges_d;
  logic        valid_q, valid_d;
  logic        busy_q, busy_d;

  logic        edge_det;
  logic        us_wrap, ms_wrap;
  logic [31:0] us_pre_step, us_cnt_step;
  logic [31:0] clk_ms_step, ms_cnt_step;

  // Next-state logic: synchroniser, counters, FSM and result registers.
  always_comb begin
    // NOTE: every signal gets a default before the case so no latch is inferred.
    state_d       = state_q;
    sync1_d       = tone_in;
    sync2_d       = sync1_q;
    sync3_d       = sync2_q;
    us_pre_d      = us_pre_q;
    us_cnt_d      = us_cnt_q;
    clk_ms_d      = clk_ms_q;
    ms_cnt_d      = ms_cnt_q;
    edge_cnt_d    = edge_cnt_q;
    last_half_d   = last_half_q;
    last_ms_d     = last_ms_q;
    have_period_d = have_period_q;
    period_d      = period_q;
    time_d        = time_q;
    edges_d       = edges_q;
    valid_d       = valid_q;

    // Any change of the synchronised level is an edge; the fixed pipeline
    // delay is the same for every edge, so intervals stay exact.
    edge_det = sync2_q ^ sync3_q;

    // Counter values after this cycle's tick; an interval ending now is
    // credited with the current clock as well, giving floor(clocks/CLK_F).
    us_wrap     = (us_pre_q == US_LAST);
    us_pre_step = us_wrap ? 32'd0 : us_pre_q + 32'd1;
    us_cnt_step = us_wrap ? sat_inc(us_cnt_q) : us_cnt_q;
    ms_wrap     = (clk_ms_q == MS_LAST);
    clk_ms_step = ms_wrap ? 32'd0 : clk_ms_q + 32'd1;
    ms_cnt_step = ms_wrap ? sat_inc(ms_cnt_q) : ms_cnt_q;

    case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (edge_det) begin
          state_d       = MEASURE;
          us_pre_d      = 32'd0;
          us_cnt_d      = 32'd0;
          clk_ms_d      = 32'd0;
          ms_cnt_d      = 32'd0;
          edge_cnt_d    = 32'd1;
          have_period_d = 1'b0;
        end
      end
      MEASURE: begin
        us_pre_d = us_pre_step;
        us_cnt_d = us_cnt_step;
        clk_ms_d = clk_ms_step;
        ms_cnt_d = ms_cnt_step;
        if (edge_det) begin
          // An edge always wins over a coincident timeout.
          last_half_d   = us_cnt_step;
          last_ms_d     = ms_cnt_step;
          edge_cnt_d    = sat_inc(edge_cnt_q);
          have_period_d = 1'b1;
          us_pre_d      = 32'd0;
          us_cnt_d      = 32'd0;
        end else if (us_cnt_q == TIMEOUT_US) begin
          if (have_period_q) begin
            period_d = last_half_q;
            time_d   = last_ms_q;
            edges_d  = edge_cnt_q;
            valid_d  = 1'b1;
            state_d  = HOLD;
          end else begin
            // A lone edge is a glitch, not a tone: drop it silently.
            state_d = IDLE;
          end
        end
      end
      HOLD: begin
        if (ack) begin
          valid_d = 1'b0;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
        valid_d = 1'b0;
      end
    endcase

    if (!enable) begin
      state_d = IDLE;
      valid_d = 1'b0;
    end

    busy_d = (state_d == MEASURE);
  end

  // State and datapath registers with asynchronous active-low reset.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      state_q       <= IDLE;
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      sync3_q       <= 1'b0;
      us_pre_q      <= 32'd0;
      us_cnt_q      <= 32'd0;
      clk_ms_q      <= 32'd0;
      ms_cnt_q      <= 32'd0;
      edge_cnt_q    <= 32'd0;
      last_half_q   <= 32'd0;
      last_ms_q     <= 32'd0;
      have_period_q <= 1'b0;
      period_q      <= 32'd0;
      time_q        <= 32'd0;
      edges_q       <= 32'd0;
      valid_q       <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      sync3_q       <= sync3_d;
      us_pre_q      <= us_pre_d;
      us_cnt_q      <= us_cnt_d;
      clk_ms_q      <= clk_ms_d;
      ms_cnt_q      <= ms_cnt_d;
      edge_cnt_q    <= edge_cnt_d;
      last_half_q   <= last_half_d;
      last_ms_q     <= last_ms_d;
      have_period_q <= have_period_d;
      period_q      <= period_d;
      time_q        <= time_d;
      edges_q       <= edges_d;
      valid_q       <= valid_d;
      busy_q        <= busy_d;
    end
  end

  assign period  = period_q;
  assign time_ms = time_q;
  assign edges   = edges_q;
  assign valid   = valid_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tone_meter.sv
// Directed bench for tone_meter. Scaled to CLK_F=4, TIMEOUT_MS=1 so one
// microsecond is 4 clocks and the silence timeout is 4000 clocks; the tone
// intervals are scaled the same way so the expected microsecond results
// match a 25 MHz setup.
module tb_tone_meter;

  localparam int unsigned CLK_F      = 4;
  localparam int unsigned TIMEOUT_MS = 1;

  logic        CLK;
  logic        RESET_N;
  logic        enable;
  logic        tone_in;
  logic        ack;
  logic [31:0] period;
  logic [31:0] time_ms;
  logic [31:0] edges;
  logic        valid;
  logic        busy;

  int checks = 0;
  int errors = 0;

  tone_meter #(
    .CLK_F      (CLK_F),
    .TIMEOUT_MS (TIMEOUT_MS)
  ) dut (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .enable  (enable),
    .tone_in (tone_in),
    .ack     (ack),
    .period  (period),
    .time_ms (time_ms),
    .edges   (edges),
    .valid   (valid),
    .busy    (busy)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge CLK);
  endtask

  // n_edges toggles of tone_in, gap clocks apart; returns at the last toggle.
  task automatic send_tone(input int n_edges, input int gap);
    for (int i = 0; i < n_edges; i++) begin
      tone_in = ~tone_in;
      if (i < n_edges - 1) tick(gap);
    end
  endtask

  // Bounded wait for valid; an expired bound shows up as valid=0 in the check.
  task automatic wait_valid(input int max_cycles);
    for (int i = 0; i < max_cycles && valid !== 1'b1; i++) tick(1);
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    tick(1);
    ack = 1'b0;
  endtask

  initial begin
    int seen_valid;

    RESET_N = 1'b0;
    enable  = 1'b0;
    tone_in = 1'b0;
    ack     = 1'b0;
    #1;
    check("reset_period", period, 32'd0);
    check("reset_time",   time_ms, 32'd0);
    check("reset_edges",  edges, 32'd0);
    check("reset_valid",  {31'd0, valid}, 32'd0);
    check("reset_busy",   {31'd0, busy}, 32'd0);
    tick(3);
    RESET_N = 1'b1;
    enable  = 1'b1;
    tick(5);

    // 200 edges, 80 clocks (20 us) apart: 15920 clocks total -> 3 ms.
    send_tone(200, 80);
    tick(3500);
    check("t1_no_early_valid", {31'd0, valid}, 32'd0);
    check("t1_busy_measuring", {31'd0, busy}, 32'd1);
    wait_valid(2000);
    check("t1_valid",  {31'd0, valid}, 32'd1);
    check("t1_busy",   {31'd0, busy}, 32'd0);
    check("t1_period", period, 32'd20);
    check("t1_edges",  edges, 32'd200);
    check("t1_time",   time_ms, 32'd3);
    pulse_ack();
    check("t1_ack_valid", {31'd0, valid}, 32'd0);
    check("t1_ack_busy",  {31'd0, busy}, 32'd0);

    // Single edge then silence: glitch, no result, back to IDLE.
    tick(10);
    tone_in = ~tone_in;
    tick(5);
    check("t2_glitch_busy", {31'd0, busy}, 32'd1);
    seen_valid = 0;
    for (int i = 0; i < 6000 && busy === 1'b1; i++) begin
      tick(1);
      if (valid === 1'b1) seen_valid = 1;
    end
    check("t2_glitch_idle",     {31'd0, busy}, 32'd0);
    check("t2_glitch_no_valid", 32'(seen_valid), 32'd0);
    check("t2_glitch_keep_per", period, 32'd20);
    // Following 10-edge tone at 40 clocks (10 us).
    tick(10);
    send_tone(10, 40);
    wait_valid(6000);
    check("t2_valid",  {31'd0, valid}, 32'd1);
    check("t2_period", period, 32'd10);
    check("t2_edges",  edges, 32'd10);
    check("t2_time",   time_ms, 32'd0);

    // HOLD: ack low for 20 cycles while tone_in toggles; result stays put.
    for (int i = 0; i < 20; i++) begin
      if (i < 12 && (i % 3) == 0) tone_in = ~tone_in;
      tick(1);
      check("t3_hold_valid",  {31'd0, valid}, 32'd1);
      check("t3_hold_period", period, 32'd10);
      check("t3_hold_edges",  edges, 32'd10);
    end
    pulse_ack();
    check("t3_ack_valid",  {31'd0, valid}, 32'd0);
    check("t3_ack_busy",   {31'd0, busy}, 32'd0);
    check("t3_keep_period", period, 32'd10);
    check("t3_keep_edges",  edges, 32'd10);

    // Uneven intervals 80, 80, 163 clocks: last one floors to 40 us.
    tick(10);
    tone_in = ~tone_in; tick(80);
    tone_in = ~tone_in; tick(80);
    tone_in = ~tone_in; tick(163);
    tone_in = ~tone_in;
    wait_valid(6000);
    check("t4_valid",  {31'd0, valid}, 32'd1);
    check("t4_period", period, 32'd40);
    check("t4_edges",  edges, 32'd4);
    check("t4_time",   time_ms, 32'd0);
    pulse_ack();

    // Asynchronous reset mid-measurement clears outputs without a clock.
    tick(10);
    send_tone(3, 80);
    tick(5);
    check("t5_busy_before_rst", {31'd0, busy}, 32'd1);
    #2;
    RESET_N = 1'b0;
    #1;
    check("t5_rst_period", period, 32'd0);
    check("t5_rst_edges",  edges, 32'd0);
    check("t5_rst_time",   time_ms, 32'd0);
    check("t5_rst_busy",   {31'd0, busy}, 32'd0);
    check("t5_rst_valid",  {31'd0, valid}, 32'd0);
    tone_in = 1'b0;
    tick(3);
    RESET_N = 1'b1;
    tick(5);
    send_tone(5, 80);
    wait_valid(6000);
    check("t5_valid",  {31'd0, valid}, 32'd1);
    check("t5_period", period, 32'd20);
    check("t5_edges",  edges, 32'd5);
    pulse_ack();

    // enable dropped mid-measurement discards it; results are kept.
    tick(10);
    send_tone(4, 80);
    tick(20);
    check("t6_busy_before", {31'd0, busy}, 32'd1);
    enable = 1'b0;
    tick(1);
    check("t6_dis_busy",   {31'd0, busy}, 32'd0);
    check("t6_dis_valid",  {31'd0, valid}, 32'd0);
    check("t6_dis_period", period, 32'd20);
    send_tone(3, 80);
    tick(10);
    check("t6_dis_ignores_tone", {31'd0, busy}, 32'd0);
    enable = 1'b1;
    tick(5);
    check("t6_en_idle", {31'd0, busy}, 32'd0);
    send_tone(3, 120);
    wait_valid(6000);
    check("t6_valid",  {31'd0, valid}, 32'd1);
    check("t6_period", period, 32'd30);
    check("t6_edges",  edges, 32'd3);
    check("t6_time",   time_ms, 32'd0);
    pulse_ack();
    check("t6_ack_valid", {31'd0, valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/tone_meter.md
Name: tone_meter

Overview:
Receive-side counterpart of the tone generator: measures an incoming square-wave tone on a single pin. Reports the half-period in microseconds (same unit and meaning as the generator's period input) and the tone duration in milliseconds. A tone ends after a silence timeout; the result is then presented with a valid/ack handshake. Sits beside the tone generator in the computer design, for loopback test and tone decoding.

Parameters:
CLK_F, 25, CLK frequency in MHz; also clocks per microsecond.
TIMEOUT_MS, 10, silence in ms (no edge) that ends a tone; must be >= 1.

Ports:
CLK  input  1  system clock, all logic on rising edge
RESET_N  input  1  asynchronous active-low reset
enable  input  1  measurement enable; low forces IDLE
tone_in  input  1  asynchronous tone input
ack  input  1  consumer accepts result; sampled only while valid=1
period  output  32  last complete half-period, microseconds
time  output  32  duration first edge to last edge, milliseconds
edges  output  32  number of edges (both polarities) in the tone
valid  output  1  result available; held until ack
busy  output  1  high in MEASURE state

Behaviour:
- Reset (RESET_N low, asynchronous): state=IDLE; period, time, edges = 0; valid = 0; busy = 0; synchroniser flops, all counters and latches = 0.
- tone_in passes through a 2-flop synchroniser, then a registered edge detector. An edge is any change of the synchronised value. The synchroniser delay is equal for all edges, so intervals are exact.
- Counters:
  - us_pre counts 0..CLK_F-1; us_cnt increments when us_pre == CLK_F-1. Both clear on every edge, so each interval = floor(clocks_between_edges / CLK_F) µs.
  - clk_ms counts 0..CLK_F*1000-1; ms_cnt increments on wrap. Both clear only on the first edge, not on later edges.
  - All 32-bit counters saturate at 32'hFFFFFFFF and never wrap.
- IDLE:
  - valid=0, busy=0.
  - First edge with enable=1 -> MEASURE. This clears us_pre, us_cnt, clk_ms and ms_cnt, and sets edge_cnt=1 and have_period=0.
- MEASURE (busy=1):
  - On each edge: last_half <= us_cnt; last_ms <= ms_cnt; edge_cnt += 1; have_period <= 1; us_pre and us_cnt clear.
  - Timeout when us_cnt == TIMEOUT_MS*1000 with no edge in that cycle. An edge in the same cycle wins and restarts the interval.
  - On timeout with have_period=1: period<=last_half, time<=last_ms, edges<=edge_cnt, valid<=1, state -> HOLD. valid is high on the cycle after the timeout condition.
  - On timeout with have_period=0 (single edge/glitch): -> IDLE, no valid, outputs unchanged.
- HOLD:
  - valid=1 and outputs stable. Edges on tone_in are ignored (no queuing).
  - ack=1 -> valid=0 on the next cycle, state -> IDLE. An edge in the same cycle as ack is ignored.
  - period/time/edges keep their last values after ack until the next result.
- enable=0 in any state: next cycle state=IDLE, valid=0, busy=0, the measurement in progress is discarded; period/time/edges keep their values.
- ack outside HOLD has no effect.
- Reset mid-measurement behaves exactly as power-on reset.
- Generator loopback (time T ms, period P µs) gives period=P, edges ≈ T*1000/P, time = floor((edges-1)*P/1000) when period is an exact µs multiple.

Test Plan:
- CLK_F=25, TIMEOUT_MS=2: 200 edges, 500 clocks apart, then silence -> valid 1 cycle after us_cnt reaches 2000; period=20, edges=200, time=3 (99500 clocks).
- Single edge, then silence 2 ms -> no valid pulse, busy 1->0, returns to IDLE; a following 10-edge tone at 250 clocks gives period=10, edges=10.
- Valid result, ack held low 20 cycles -> valid and outputs stable, tone_in edges ignored; ack=1 for 1 cycle -> valid=0 next cycle, busy=0.
- Uneven intervals of 500, 500, 1000 clocks -> period=40 (last interval), edges=4.
- RESET_N low mid-MEASURE for 3 cycles (no CLK edge) -> outputs 0 immediately; after release, a fresh 20 µs tone measures correctly.
- enable dropped mid-MEASURE -> no valid, state IDLE; enable=1 again and the next tone is measured from its first edge.
